// File: rtl/stream_mux_n_pkg.sv
// Shared constants for the registered N-to-1 stream multiplexer.
// MODE is an elaboration-time choice between explicit select and round-robin.
package stream_mux_n_pkg;

    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;

endpackage

// File: rtl/stream_mux_n_if.sv
// Bundles the N input channels and the single output stream of stream_mux_n.
// slave is the multiplexer's own view; master is the view of the producers and consumer around it.
interface stream_mux_n_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
) ();

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SEL_W-1:0]   out_src;

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, out_src
    );

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, out_src
    );

endinterface

// File: rtl/stream_mux_n_rr_arbiter.sv
// Combinational round-robin search: grants the first requester strictly after ptr,
// wrapping modulo N; ptr is always a legal channel index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [SEL_W-1:0] gnt_idx
);

    // NOTE: every always_comb output gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        // Walk from the farthest offset to the nearest so the closest requester wins last.
        for (int k = N; k >= 1; k--) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// Registered N-to-1 stream multiplexer with one output stage and backpressure.
// MODE picks explicit select or round-robin arbitration at elaboration.
module stream_mux_n
    import stream_mux_n_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter int MODE  = MUX_MODE_SEL
) (
    input logic            clk,
    input logic            rst,
    stream_mux_n_if.slave  bus
);

    logic             space;
    logic             ready_en;
    logic             xfer;
    logic [SEL_W-1:0] gnt_idx;
    logic [N-1:0]     ready;
    logic [WIDTH-1:0] gnt_data;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_src_q;

    assign space = !out_valid_q || bus.out_ready;

    generate
        if (MODE == MUX_MODE_RR) begin : g_rr
            logic [SEL_W-1:0] ptr;
            logic             gnt_vld;

            rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
                .req     (bus.in_valid),
                .ptr     (ptr),
                .gnt_vld (gnt_vld),
                .gnt_idx (gnt_idx)
            );

            assign ready_en = gnt_vld;

            // Reset to N-1 so the first search starts at channel 0.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)       ptr <= SEL_W'(N - 1);
                else if (xfer) ptr <= gnt_idx;
            end
        end else begin : g_sel
            // The selected channel is offered space even when it is not yet valid.
            assign gnt_idx  = bus.sel;
            assign ready_en = (int'(bus.sel) < N);
        end
    endgenerate

    always_comb begin
        ready    = '0;
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                ready[i] = space && ready_en && !rst;
                gnt_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(ready & bus.in_valid);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else if (space) begin
            out_valid_q <= xfer;
            if (xfer) begin
                out_data_q <= gnt_data;
                out_src_q  <= gnt_idx;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: select mode with N=4 and N=3, round-robin with N=4, all
// fed the same stimulus and compared against a transaction-level reference model.
module tb_stream_mux_n;
    import stream_mux_n_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] d [4];
    logic [3:0]  v;
    logic [1:0]  s;
    logic        ordy;

    int checks;
    int errors;

    stream_mux_n_if #(.WIDTH(32), .N(4), .SEL_W(2)) if_s4 ();
    stream_mux_n_if #(.WIDTH(32), .N(3), .SEL_W(2)) if_s3 ();
    stream_mux_n_if #(.WIDTH(32), .N(4), .SEL_W(2)) if_r4 ();

    assign if_s4.in_data   = {d[3], d[2], d[1], d[0]};
    assign if_s4.in_valid  = v;
    assign if_s4.sel       = s;
    assign if_s4.out_ready = ordy;
    assign if_s3.in_data   = {d[2], d[1], d[0]};
    assign if_s3.in_valid  = v[2:0];
    assign if_s3.sel       = s;
    assign if_s3.out_ready = ordy;
    assign if_r4.in_data   = {d[3], d[2], d[1], d[0]};
    assign if_r4.in_valid  = v;
    assign if_r4.sel       = s;
    assign if_r4.out_ready = ordy;

    stream_mux_n #(.WIDTH(32), .N(4), .SEL_W(2), .MODE(MUX_MODE_SEL)) u_s4 (.clk(clk), .rst(rst), .bus(if_s4));
    stream_mux_n #(.WIDTH(32), .N(3), .SEL_W(2), .MODE(MUX_MODE_SEL)) u_s3 (.clk(clk), .rst(rst), .bus(if_s3));
    stream_mux_n #(.WIDTH(32), .N(4), .SEL_W(2), .MODE(MUX_MODE_RR))  u_r4 (.clk(clk), .rst(rst), .bus(if_r4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one output slot and a last-grant pointer per instance.
    int          cfg_n  [3] = '{4, 3, 4};
    bit          cfg_rr [3] = '{1'b0, 1'b0, 1'b1};
    logic        m_valid[3];
    logic [31:0] m_data [3];
    int          m_src  [3];
    int          m_ptr  [3];

    function automatic logic [3:0] get_ready(int k);
        case (k)
            0:       return if_s4.in_ready;
            1:       return {1'b0, if_s3.in_ready};
            default: return if_r4.in_ready;
        endcase
    endfunction

    function automatic logic get_valid(int k);
        case (k)
            0:       return if_s4.out_valid;
            1:       return if_s3.out_valid;
            default: return if_r4.out_valid;
        endcase
    endfunction

    function automatic logic [31:0] get_data(int k);
        case (k)
            0:       return if_s4.out_data;
            1:       return if_s3.out_data;
            default: return if_r4.out_data;
        endcase
    endfunction

    function automatic logic [1:0] get_src(int k);
        case (k)
            0:       return if_s4.out_src;
            1:       return if_s3.out_src;
            default: return if_r4.out_src;
        endcase
    endfunction

    // Channel offered space this cycle, or -1 when nobody is.
    function automatic int model_grant(int k);
        if (m_valid[k] && !ordy) return -1;
        if (!cfg_rr[k]) return (int'(s) < cfg_n[k]) ? int'(s) : -1;
        for (int step = 1; step <= cfg_n[k]; step++) begin
            int c;
            c = (m_ptr[k] + step) % cfg_n[k];
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
            m_src[k]   = 0;
            m_ptr[k]   = cfg_n[k] - 1;
        end
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_u%0d_out_valid", tag, k), 64'(get_valid(k)), 64'(m_valid[k]));
            check($sformatf("%s_u%0d_out_data", tag, k), 64'(get_data(k)), 64'(m_data[k]));
            check($sformatf("%s_u%0d_out_src", tag, k), 64'(get_src(k)), 64'(m_src[k]));
        end
    endtask

    // Entered one time unit after a rising edge with inputs already driven.
    task automatic cycle(string tag);
        int   g  [3];
        logic xf [3];
        logic sp [3];
        #1;
        for (int k = 0; k < 3; k++) begin
            logic [3:0] exp_ready;
            g[k]      = model_grant(k);
            sp[k]     = !m_valid[k] || ordy;
            exp_ready = (g[k] >= 0) ? 4'(1 << g[k]) : 4'h0;
            xf[k]     = (g[k] >= 0) && v[g[k]];
            check($sformatf("%s_u%0d_in_ready", tag, k), 64'(get_ready(k)), 64'(exp_ready));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (sp[k]) begin
                m_valid[k] = xf[k];
                if (xf[k]) begin
                    m_data[k] = d[g[k]];
                    m_src[k]  = g[k];
                    m_ptr[k]  = g[k];
                end
            end
        end
        check_outputs(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();

        // Reset state; in_ready must stay low while rst is high even with requests pending.
        rst  = 1'b1;
        v    = 4'hF;
        s    = 2'd0;
        ordy = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = 32'h100 + i;
        #2;
        check("rst_s4_in_ready", 64'(if_s4.in_ready), 64'h0);
        check("rst_s3_in_ready", 64'(if_s3.in_ready), 64'h0);
        check("rst_r4_in_ready", 64'(if_r4.in_ready), 64'h0);
        check_outputs("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        v   = 4'h0;
        cycle("idle0");
        cycle("idle1");

        // Select mode: sel=2 with channels 1 and 2 valid.
        s    = 2'd2;
        v    = 4'b0110;
        d[2] = 32'hDEADBEEF;
        #1;
        check("sel2_s4_in_ready", 64'(if_s4.in_ready), 64'h4);
        cycle("sel2");
        check("sel2_s4_data", 64'(if_s4.out_data), 64'hDEADBEEF);
        check("sel2_s4_src", 64'(if_s4.out_src), 64'd2);

        // Out-of-range select on the three-channel instance.
        s = 2'd3;
        v = 4'hF;
        #1;
        check("sel3_s3_in_ready", 64'(if_s3.in_ready), 64'h0);
        cycle("sel3");
        check("sel3_s3_out_valid", 64'(if_s3.out_valid), 64'h0);

        // Backpressure: park 0x11, stall five cycles while 0x22 waits on channel 0.
        s    = 2'd0;
        v    = 4'b0001;
        d[0] = 32'h11;
        cycle("bp_load");
        ordy = 1'b0;
        d[0] = 32'h22;
        for (int i = 0; i < 5; i++) begin
            cycle($sformatf("bp_hold%0d", i));
            check($sformatf("bp_hold%0d_s4_data", i), 64'(if_s4.out_data), 64'h11);
            check($sformatf("bp_hold%0d_s4_ready", i), 64'(if_s4.in_ready), 64'h0);
        end
        ordy = 1'b1;
        cycle("bp_release");
        check("bp_release_s4_data", 64'(if_s4.out_data), 64'h22);

        // Asynchronous reset with a word held: outputs clear without a clock edge.
        check("mid_rst_pre_valid", 64'(if_s4.out_valid), 64'h1);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("mid_rst");
        v = 4'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("post_rst0");
        cycle("post_rst1");
        check("post_rst_r4_valid", 64'(if_r4.out_valid), 64'h0);

        // Round-robin fairness with every channel valid.
        v = 4'hF;
        for (int i = 0; i < 4; i++) d[i] = 32'(i + 1);
        for (int i = 0; i < 8; i++) begin
            cycle($sformatf("rr%0d", i));
            check($sformatf("rr%0d_r4_src", i), 64'(if_r4.out_src), 64'(i % 4));
            check($sformatf("rr%0d_r4_data", i), 64'(if_r4.out_data), 64'(i % 4 + 1));
        end

        // Wrap-around after a channel 3 grant.
        v = 4'b1010;
        cycle("wrap_a");
        check("wrap_a_r4_src", 64'(if_r4.out_src), 64'd1);
        v = 4'b1000;
        cycle("wrap_b");
        check("wrap_b_r4_src", 64'(if_r4.out_src), 64'd3);
        cycle("wrap_c");
        check("wrap_c_r4_src", 64'(if_r4.out_src), 64'd3);

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            v    = 4'($urandom);
            s    = 2'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 4; c++) d[c] = $urandom;
            cycle($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
